serial_borrow_sub: RTL



---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_borrow_sub_fs.sv | 15 +
 rtl/serial_borrow_sub.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial borrow subtractor.
//   state_t        : FSM state encoding (IDLE, RUN, DONE)
//   maj3           : 2-of-3 majority vote
//   DEFAULT_WIDTH  : default operand width
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_borrow_sub_fs.sv
// Combinational full subtractor cell: d = x - y - bin (one bit).
//   x, y, bin : minuend bit, subtrahend bit, borrow-in
//   d, bo     : difference bit, borrow-out
module fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_borrow_sub.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, LSB first,
// one bit per clock through a single full-subtractor cell.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : operand handshake (a, b, bin)
//   out_valid / out_ready  : result handshake (diff, bout)
//   borrow_fault           : one-cycle pulse on borrow copy disagreement
// Optional build macro SERIAL_SUB_BORROW_TMR_EN triplicates the borrow
// register with majority voting; without it borrow_fault is tied low.
module serial_borrow_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             borrow_fault
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] d_sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             bout_q;

  logic accept;
  logic last_bit;
  logic br_v;
  logic br_we;
  logic br_d;
  logic fs_d;
  logic fs_bo;

  assign accept   = in_valid && in_ready_q;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Borrow register load: bin on accept, cell borrow-out while running
  always_comb begin
    br_we = 1'b0;
    br_d  = br_v;
    case (state_q)
      IDLE: begin
        if (accept) begin
          br_we = 1'b1;
          br_d  = bin;
        end
      end
      RUN: begin
        br_we = 1'b1;
        br_d  = fs_bo;
      end
      default: br_we = 1'b0;
    endcase
  end

`ifdef SERIAL_SUB_BORROW_TMR_EN
  logic br0_q, br1_q, br2_q;
  logic br_mismatch;
  logic borrow_fault_q;

  assign br_v        = maj3(br0_q, br1_q, br2_q);
  assign br_mismatch = (br0_q ^ br1_q) | (br1_q ^ br2_q);

  // All copies reload from the same (voted) value, scrubbing any upset
  always_ff @(posedge clk) begin
    if (rst) begin
      br0_q          <= 1'b0;
      br1_q          <= 1'b0;
      br2_q          <= 1'b0;
      borrow_fault_q <= 1'b0;
    end else begin
      if (br_we) begin
        br0_q <= br_d;
        br1_q <= br_d;
        br2_q <= br_d;
      end
      borrow_fault_q <= ((state_q == RUN) || (state_q == DONE)) && br_mismatch;
    end
  end

  assign borrow_fault = borrow_fault_q;
`else
  logic br_q;

  assign br_v = br_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= 1'b0;
    end else if (br_we) begin
      br_q <= br_d;
    end
  end

  assign borrow_fault = 1'b0;
`endif

  fs u_fs (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .bin(br_v),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Control FSM with operand/result shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      d_sr_q      <= '0;
      cnt_q       <= '0;
      bout_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sr_q     <= a;
            b_sr_q     <= b;
            d_sr_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          // new bit enters at the MSB so the LSB-first result lands aligned
          d_sr_q <= (d_sr_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
          if (last_bit) begin
            bout_q      <= fs_bo;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = d_sr_q;
  assign bout      = bout_q;

endmodule
